// File: rtl/csa_pipe_addsub.sv
// ---------------------------------------------------------------------------
// csa_pipe_addsub
//
// Two-stage pipelined carry-select adder/subtractor with valid/ready
// handshakes on the operand and result sides.
//
//   Stage 1: each BLOCK-bit slice precomputes its conditional sums.
//            Slice 0 adds the real carry-in directly. Every higher slice
//            keeps both the carry-in=0 and the carry-in=1 results.
//   Stage 2: the block carry ripples slice to slice through 2:1 muxes,
//            which pick one of the precomputed sums. The result, the
//            carry/borrow out and the overflow flag are then registered.
//
// Subtraction is a + ~b + ~cin, so cin acts as a borrow-in when sub=1.
// In that mode cout is the inverted final carry, which makes it a borrow
// flag (1 = borrow).
//
// Parameters
//   WIDTH  operand/result width. It must be a multiple of BLOCK and at
//          least BLOCK.
//   BLOCK  carry-select slice width.
//
// Build option
//   CSA_OVF_EN  When defined, stage 1 captures the MSBs of a and b' and
//               drives ovf with two's-complement overflow. When undefined,
//               ovf is tied to 0 and no MSB registers exist.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block accepts a beat this cycle (comb from out_ready)
//   a, b       in   operands, WIDTH bits
//   cin        in   carry-in (add) / borrow-in (sub)
//   sub        in   0: a+b+cin   1: a-b-cin
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   sum        out  result modulo 2^WIDTH
//   cout       out  carry-out (add) / borrow-out (sub)
//   ovf        out  two's-complement overflow (0 without CSA_OVF_EN)
// ---------------------------------------------------------------------------
module csa_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;

    // ------------------------------------------------------------------
    // Effective operands for the shared adder
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    // ------------------------------------------------------------------
    // Handshake / pipeline control
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s1_load, s2_load;

    // Stage 2 can take new data when it is empty or is draining this cycle.
    assign s2_load = s1_valid_q && (!out_valid_q || out_ready);

    // Stage 1 can take a beat when it is empty, or when its content is
    // moving on to stage 2 this cycle. in_ready is held low during reset,
    // so nothing is accepted while the pipeline is being cleared.
    assign in_ready = rst_n && (!s1_valid_q || !out_valid_q || out_ready);
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 side-band registers (data only, qualified by s1_valid_q)
    // ------------------------------------------------------------------
    logic sub_q;
`ifdef CSA_OVF_EN
    logic a_msb_q;
    logic bp_msb_q;
`endif

    always_ff @(posedge clk) begin
        if (s1_load) begin
            sub_q    <= sub;
`ifdef CSA_OVF_EN
            a_msb_q  <= a[WIDTH-1];
            bp_msb_q <= b_eff[WIDTH-1];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Per-slice conditional sums (stage 1) and carry-select (stage 2)
    // ------------------------------------------------------------------
    // carry[i] is the carry into slice i, for i = 1..NBLK. carry[NBLK] is
    // the carry out of the whole word.
    logic [NBLK:1]    carry;
    logic [WIDTH-1:0] sum_d;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_slice
            logic [BLOCK:0] a_ext;
            logic [BLOCK:0] b_ext;
            logic [BLOCK:0] sel;

            assign a_ext = {1'b0, a[gi*BLOCK +: BLOCK]};
            assign b_ext = {1'b0, b_eff[gi*BLOCK +: BLOCK]};

            if (gi == 0) begin : g_lsb
                // The lowest slice sees the real carry-in, so only one
                // sum needs to be kept and there is nothing to select.
                logic [BLOCK:0] s_q;

                always_ff @(posedge clk) begin
                    if (s1_load) begin
                        s_q <= a_ext + b_ext + {{BLOCK{1'b0}}, c0};
                    end
                end

                assign sel = s_q;
            end else begin : g_upper
                logic [BLOCK:0] s0_q;
                logic [BLOCK:0] s1_q;

                always_ff @(posedge clk) begin
                    if (s1_load) begin
                        s0_q <= a_ext + b_ext;
                        s1_q <= a_ext + b_ext + {{BLOCK{1'b0}}, 1'b1};
                    end
                end

                // The carry from the slice below picks which precomputed
                // sum (and therefore which carry-out) is the real one.
                assign sel = carry[gi] ? s1_q : s0_q;
            end

            assign sum_d[gi*BLOCK +: BLOCK] = sel[BLOCK-1:0];
            assign carry[gi+1]              = sel[BLOCK];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2 result flags
    // ------------------------------------------------------------------
    logic cout_d;

    // When subtracting, a carry out means there was no borrow.
    assign cout_d = sub_q ? ~carry[NBLK] : carry[NBLK];

`ifdef CSA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow occurs when both addends share a sign and the result's
    // sign differs from it.
    assign ovf_d = (a_msb_q ^ sum_d[WIDTH-1]) & (bp_msb_q ^ sum_d[WIDTH-1]);
`endif

    // ------------------------------------------------------------------
    // Stage 2 registers and valid flags
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef CSA_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            // sum/cout/ovf change only on a stage-2 load, so they stay
            // stable while the consumer stalls.
            if (s2_load) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef CSA_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CSA_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_csa_pipe_addsub.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_addsub
//
// Directed bench for csa_pipe_addsub (WIDTH=32, BLOCK=8). It covers reset
// behaviour, carry-select across slices, subtraction with borrow and
// overflow, back-pressure with two beats in flight, and reset while beats
// are in flight. Expected values are hand-computed constants. The overflow
// expectation follows whether CSA_OVF_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_csa_pipe_addsub;

    localparam int WIDTH = 32;
    localparam int BLOCK = 8;

`ifdef CSA_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    csa_pipe_addsub #(
        .WIDTH(WIDTH),
        .BLOCK(BLOCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Absolute time bound. Every step below is a fixed number of cycles,
    // so this should never be reached.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic sv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
    endtask

    // One beat through an idle pipeline with out_ready high. The beat is
    // accepted at edge k. out_valid must still be 0 after edge k and must
    // be 1, with the result, after edge k+1.
    task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input logic sv,
                      input logic [31:0] es, input logic ec, input logic eo);
        @(negedge clk);
        drive(av, bv, cv, sv);
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".lat"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, {31'b0, cout}, {31'b0, ec});
        chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
        $display("txn %s: a=%08h b=%08h cin=%0d sub=%0d -> sum=%08h cout=%0d ovf=%0d",
                 tag, av, bv, cv, sv, sum, cout, ovf);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.sum", sum, 32'd0);
        chk("rst.cout", {31'b0, cout}, 32'd0);
        chk("rst.ovf", {31'b0, ovf}, 32'd0);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rel.out_valid", {31'b0, out_valid}, 32'd0);

        // ---------------- carry select / add ----------------
        op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        op("add_chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        op("add_mid",    32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

        // ---------------- subtract ----------------
        op("sub_5_7",    32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        op("sub_min_1",  32'h8000_0000, 32'd1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, OVF_ON);
        op("sub_brw",    32'd10,        32'd3,         1'b1, 1'b1, 32'd6,         1'b0, 1'b0);

        // ---------------- overflow on add ----------------
        op("add_ovf",    32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);

        // ---------------- back-pressure ----------------
        @(negedge clk);
        out_ready = 1'b0;
        drive(32'd1, 32'd1, 1'b0, 1'b0);
        chk("bp.acc1", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(32'd2, 32'd2, 1'b0, 1'b0);
        chk("bp.acc2", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(32'd3, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp.full", {31'b0, in_ready}, 32'd0);
            chk("bp.hold_v", {31'b0, out_valid}, 32'd1);
            chk("bp.hold_s", sum, 32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.ready_comb", {31'b0, in_ready}, 32'd1);
        chk("bp.r1", sum, 32'd2);
        $display("txn bp: result=%0d", sum);
        @(negedge clk);
        drive(32'd4, 32'd4, 1'b0, 1'b0);
        chk("bp.r2_v", {31'b0, out_valid}, 32'd1);
        chk("bp.r2", sum, 32'd4);
        chk("bp.acc4", {31'b0, in_ready}, 32'd1);
        $display("txn bp: result=%0d", sum);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.r3_v", {31'b0, out_valid}, 32'd1);
        chk("bp.r3", sum, 32'd6);
        $display("txn bp: result=%0d", sum);
        @(negedge clk);
        chk("bp.r4_v", {31'b0, out_valid}, 32'd1);
        chk("bp.r4", sum, 32'd8);
        $display("txn bp: result=%0d", sum);
        @(negedge clk);
        chk("bp.drain", {31'b0, out_valid}, 32'd0);

        // ---------------- reset mid-flight ----------------
        out_ready = 1'b0;
        drive(32'd9, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'd10, 32'd10, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid.inflight", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid.rst_v", {31'b0, out_valid}, 32'd0);
        chk("mid.rst_s", sum, 32'd0);
        chk("mid.rst_rdy", {31'b0, in_ready}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid.no_ghost", {31'b0, out_valid}, 32'd0);
        end

        // Pipeline still works after the mid-flight reset.
        op("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csa_pipe_addsub.md
# csa_pipe_addsub

Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshakes on both sides. Stage 1 computes both conditional sums (carry-in 0 and 1) for every BLOCK-bit slice. Stage 2 resolves the block carry chain through per-block 2:1 selection. It is the registered, width-generic successor to the single-bit select primitive. It sits between operand producers and result consumers in the adder datapath.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLOCK, and WIDTH >= BLOCK
- BLOCK, 8, carry-select slice width; WIDTH/BLOCK slices
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result modulo 2^WIDTH
- cout  out  1  add: carry-out; sub: borrow-out (1 = borrow)
- ovf  out  1  two's-complement overflow (see Configuration)

## Operation
- Effective operands: b' = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Stage 1, on accept (in_valid && in_ready):
  - Slice 0 registers a[BLOCK-1:0]+b'[BLOCK-1:0]+c0 (BLOCK+1 bits).
  - Every slice i>0 registers s0_i = a_i+b'_i and s1_i = a_i+b'_i+1 (BLOCK+1 bits each).
  - Registers sub, a MSB, b' MSB. Sets s1_valid.
- Stage 2, on s2 load:
  - Carry c_1 = slice 0 carry.
  - Slice i>0 output = c_i ? s1_i : s0_i; c_{i+1} = selected carry.
  - Registers sum, cout = sub ? ~c_N : c_N, and ovf. Sets out_valid.
- Load rules:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = rst_n && (!s1_valid || !out_valid || out_ready).
  - Bubbles collapse: an empty stage always accepts.
- Handshake:
  - out_valid/sum/cout/ovf hold stable while out_valid && !out_ready.
  - Output drops to 0-valid after a transfer with no stage-1 data behind it.
  - Results leave in acceptance order; no reordering, no drop.
- Simultaneous events: a new beat may be accepted in the same cycle that stage 1 moves to stage 2 and stage 2 transfers out.
- Reset: while rst_n is low at an edge, s1_valid, out_valid, sum, cout, and ovf clear to 0. In-flight beats are discarded. in_ready is 0 while rst_n is low.

## Timing
- Latency: beat accepted at edge k produces out_valid=1 after edge k+1. Result visible in the cycle following edge k+1 (2 register stages).
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 2 beats in flight. With out_ready=0, in_ready falls after the second accept.
- in_ready is combinational from out_ready; no other comb input-to-output path.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the first cycle after rst_n rises.

## Configuration
- CSA_OVF_EN defined: stage 1 keeps a/b' MSBs.
  - ovf = (a_msb ^ sum_msb) & (b'_msb ^ sum_msb), registered with sum.
- CSA_OVF_EN undefined: no MSB capture registers; ovf tied to 0. Port list unchanged.

## Test plan
WIDTH=32, BLOCK=8, CSA_OVF_EN defined unless stated.
- Reset: rst_n=0 for 2 cycles with in_valid=1, a=b=0xFFFFFFFF → out_valid=0, sum=0, cout=0, ovf=0, in_ready=0. Next cycle after release: in_ready=1.
- Carry select:
  - a=0x000000FF, b=0x1, cin=0, sub=0 → sum=0x00000100, cout=0, out_valid after 2 edges.
  - a=0xFFFFFFFF, b=0, cin=1 → sum=0, cout=1 (full-chain select).
- Subtract:
  - a=5, b=7, cin=0, sub=1 → sum=0xFFFFFFFE, cout=1, ovf=0.
  - a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=0, ovf=1.
- Back-pressure: out_ready=0, 4 consecutive beats 1+1, 2+2, 3+3, 4+4 → only 2 accepted, in_ready=0 afterwards, sum=2 held stable. Raise out_ready → results 2, 4, 6, 8 in order, 1 per cycle, no loss.
- Reset mid-flight: 2 beats in flight, rst_n=0 one cycle → out_valid=0 after that edge. Both beats never appear.
- Overflow config: a=0x7FFFFFFF, b=1, add → ovf=1 with CSA_OVF_EN, ovf=0 without. sum=0x80000000 in both builds.
